// File: rtl/arithmetic_logic_unit_controller_if.sv
// Control bus between the ALU sequencer and its datapath.
// The master end is the sequencer; the slave end is the datapath.
interface arithmetic_logic_unit_controller_if;
   logic [15:0] IROut;
   logic [3:0]  FlagsOut;
   logic [1:0]  MuxASel;
   logic [1:0]  MuxBSel;
   logic        MuxCSel;
   logic [2:0]  RF_OutASel;
   logic [2:0]  RF_OutBSel;
   logic [2:0]  RF_FunSel;
   logic [3:0]  RF_RegSel;
   logic [3:0]  RF_ScrSel;
   logic [4:0]  ALU_FunSel;
   logic        ALU_WF;
   logic [1:0]  ARF_OutCSel;
   logic [1:0]  ARF_OutDSel;
   logic [2:0]  ARF_FunSel;
   logic [2:0]  ARF_RegSel;
   logic        IR_LH;
   logic        IR_Write;
   logic        Mem_WR;
   logic        Mem_CS;
   logic [2:0]  State;
   logic        InstrDone;

   modport master (
      input  IROut, FlagsOut,
      output MuxASel, MuxBSel, MuxCSel,
      output RF_OutASel, RF_OutBSel, RF_FunSel,
      output RF_RegSel, RF_ScrSel,
      output ALU_FunSel, ALU_WF,
      output ARF_OutCSel, ARF_OutDSel,
      output ARF_FunSel, ARF_RegSel,
      output IR_LH, IR_Write, Mem_WR, Mem_CS,
      output State, InstrDone
   );

   modport slave (
      output IROut, FlagsOut,
      input  MuxASel, MuxBSel, MuxCSel,
      input  RF_OutASel, RF_OutBSel, RF_FunSel,
      input  RF_RegSel, RF_ScrSel,
      input  ALU_FunSel, ALU_WF,
      input  ARF_OutCSel, ARF_OutDSel,
      input  ARF_FunSel, ARF_RegSel,
      input  IR_LH, IR_Write, Mem_WR, Mem_CS,
      input  State, InstrDone
   );
endinterface

// File: rtl/arithmetic_logic_unit_controller.sv
// Moore sequencer for a small 16-bit ALU datapath (fetch, 1-2 exec states).
// Define ALU_CTRL_HALT_EN to make opcode 0xF a halting HLT.
module arithmetic_logic_unit_controller (
   input logic Clock,
   input logic Reset,
   arithmetic_logic_unit_controller_if.master bus
);
   typedef enum logic [2:0] {
      FETCH_L = 3'd0,
      FETCH_H = 3'd1,
      EXEC1   = 3'd2,
      EXEC2   = 3'd3,
      HALT    = 3'd4
   } state_t;

   localparam logic [3:0] OP_BRA = 4'h0;
   localparam logic [3:0] OP_BNE = 4'h1;
   localparam logic [3:0] OP_LDI = 4'h2;
   localparam logic [3:0] OP_ADD = 4'h3;
   localparam logic [3:0] OP_LD  = 4'h4;
   localparam logic [3:0] OP_ST  = 4'h5;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [2:0] FUN_LOAD = 3'b010;
   localparam logic [2:0] FUN_INC  = 3'b001;
   localparam logic [2:0] SEL_PC   = 3'b100;
   localparam logic [2:0] SEL_AR   = 3'b010;
   localparam logic [1:0] OUTD_PC  = 2'b00;
   localparam logic [1:0] OUTD_AR  = 2'b01;
   localparam logic [4:0] ALU_ADD  = 5'b10100;
   localparam logic [4:0] ALU_PASS = 5'b10000;

   state_t     state;
   logic [3:0] opcode;
   logic [1:0] rx;
   logic [1:0] ry;
   logic [3:0] rx_hot;
   logic       unused;

   assign opcode = bus.IROut[15:12];
   assign rx     = bus.IROut[11:10];
   assign ry     = bus.IROut[9:8];
   assign rx_hot = 4'b1000 >> rx;
   assign unused = ^{bus.IROut[7:0], bus.FlagsOut[2:0]};

   assign bus.State = state;

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state <= FETCH_L;
      end else begin
         case (state)
            FETCH_L: state <= FETCH_H;
            FETCH_H: state <= EXEC1;
            EXEC1: begin
               if (opcode == OP_LD || opcode == OP_ST)
                  state <= EXEC2;
`ifdef ALU_CTRL_HALT_EN
               else if (opcode == OP_HLT)
                  state <= HALT;
`endif
               else
                  state <= FETCH_L;
            end
            EXEC2: state <= FETCH_L;
`ifdef ALU_CTRL_HALT_EN
            HALT:  state <= HALT;
`endif
            default: state <= FETCH_L;
         endcase
      end
   end

   // Reset gates every strobe so nothing writes while Reset is low.
   always_comb begin
      bus.MuxASel     = 2'b00;
      bus.MuxBSel     = 2'b00;
      bus.MuxCSel     = 1'b0;
      bus.RF_OutASel  = 3'b000;
      bus.RF_OutBSel  = 3'b000;
      bus.RF_FunSel   = 3'b000;
      bus.RF_RegSel   = 4'b0000;
      bus.RF_ScrSel   = 4'b0000;
      bus.ALU_FunSel  = 5'b00000;
      bus.ALU_WF      = 1'b0;
      bus.ARF_OutCSel = 2'b00;
      bus.ARF_OutDSel = 2'b00;
      bus.ARF_FunSel  = 3'b000;
      bus.ARF_RegSel  = 3'b000;
      bus.IR_LH       = 1'b0;
      bus.IR_Write    = 1'b0;
      bus.Mem_WR      = 1'b0;
      bus.Mem_CS      = 1'b1;
      bus.InstrDone   = 1'b0;
      if (Reset) begin
         case (state)
            FETCH_L, FETCH_H: begin
               bus.ARF_OutDSel = OUTD_PC;
               bus.Mem_CS      = 1'b0;
               bus.IR_Write    = 1'b1;
               bus.IR_LH       = (state == FETCH_H);
               bus.ARF_RegSel  = SEL_PC;
               bus.ARF_FunSel  = FUN_INC;
            end
            EXEC1: begin
               bus.InstrDone = 1'b1;
               case (opcode)
                  OP_BRA: begin
                     bus.MuxBSel    = 2'b11;
                     bus.ARF_RegSel = SEL_PC;
                     bus.ARF_FunSel = FUN_LOAD;
                  end
                  OP_BNE: begin
                     if (!bus.FlagsOut[3]) begin
                        bus.MuxBSel    = 2'b11;
                        bus.ARF_RegSel = SEL_PC;
                        bus.ARF_FunSel = FUN_LOAD;
                     end
                  end
                  OP_LDI: begin
                     bus.MuxASel   = 2'b11;
                     bus.RF_RegSel = rx_hot;
                     bus.RF_FunSel = FUN_LOAD;
                  end
                  OP_ADD: begin
                     bus.RF_OutASel = {1'b0, rx};
                     bus.RF_OutBSel = {1'b0, ry};
                     bus.ALU_FunSel = ALU_ADD;
                     bus.ALU_WF     = 1'b1;
                     bus.MuxASel    = 2'b00;
                     bus.RF_RegSel  = rx_hot;
                     bus.RF_FunSel  = FUN_LOAD;
                  end
                  OP_LD, OP_ST: begin
                     bus.InstrDone  = 1'b0;
                     bus.MuxBSel    = 2'b11;
                     bus.ARF_RegSel = SEL_AR;
                     bus.ARF_FunSel = FUN_LOAD;
                  end
                  default: ;
               endcase
            end
            EXEC2: begin
               bus.InstrDone = 1'b1;
               if (opcode == OP_LD) begin
                  bus.ARF_OutDSel = OUTD_AR;
                  bus.Mem_CS      = 1'b0;
                  bus.MuxASel     = 2'b10;
                  bus.RF_RegSel   = rx_hot;
                  bus.RF_FunSel   = FUN_LOAD;
               end else if (opcode == OP_ST) begin
                  bus.ARF_OutDSel = OUTD_AR;
                  bus.RF_OutASel  = {1'b0, rx};
                  bus.ALU_FunSel  = ALU_PASS;
                  bus.MuxCSel     = 1'b0;
                  bus.Mem_CS      = 1'b0;
                  bus.Mem_WR      = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_arithmetic_logic_unit_controller.sv
// Directed bench for the ALU sequencer: fetch/exec timing, decode, reset.
module tb_arithmetic_logic_unit_controller;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   arithmetic_logic_unit_controller_if bus ();

   arithmetic_logic_unit_controller dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.IROut    = 16'h2A55;
      bus.FlagsOut = 4'b0000;
      rst = 1'b0;
      step();
      step();
      checks++;
      if (bus.State !== 3'd0) begin
         errors++;
         $display("FAIL reset_state got=%0d want=0", bus.State);
      end
      checks++;
      if ({bus.Mem_CS, bus.IR_Write, bus.ARF_RegSel, bus.InstrDone}
          !== 6'b1_0_000_0) begin
         errors++;
         $display("FAIL reset_idle got=%b%b%b%b want=100000",
                  bus.Mem_CS, bus.IR_Write, bus.ARF_RegSel, bus.InstrDone);
      end
   endtask

   task automatic test_ldi();
      bus.IROut = 16'h2A55;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.State, bus.ARF_OutDSel, bus.Mem_CS, bus.IR_Write,
           bus.IR_LH, bus.ARF_RegSel, bus.ARF_FunSel, bus.InstrDone}
          !== {3'd0, 2'b00, 1'b0, 1'b1, 1'b0, 3'b100, 3'b001, 1'b0}) begin
         errors++;
         $display("FAIL fetch_l got st=%0d cs=%b irw=%b lh=%b rs=%b fs=%b d=%b",
                  bus.State, bus.Mem_CS, bus.IR_Write, bus.IR_LH,
                  bus.ARF_RegSel, bus.ARF_FunSel, bus.InstrDone);
      end
      step();
      checks++;
      if ({bus.State, bus.IR_LH, bus.IR_Write, bus.Mem_CS, bus.InstrDone}
          !== {3'd1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL fetch_h got st=%0d lh=%b irw=%b cs=%b d=%b",
                  bus.State, bus.IR_LH, bus.IR_Write, bus.Mem_CS,
                  bus.InstrDone);
      end
      step();
      checks++;
      if ({bus.State, bus.MuxASel, bus.RF_RegSel, bus.RF_FunSel,
           bus.InstrDone, bus.IR_Write}
          !== {3'd2, 2'b11, 4'b0010, 3'b010, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL ldi_exec1 got st=%0d ma=%b rs=%b fs=%b d=%b irw=%b",
                  bus.State, bus.MuxASel, bus.RF_RegSel, bus.RF_FunSel,
                  bus.InstrDone, bus.IR_Write);
      end
      step();
      checks++;
      if ({bus.State, bus.InstrDone} !== {3'd0, 1'b0}) begin
         errors++;
         $display("FAIL ldi_next got st=%0d d=%b want st=0 d=0",
                  bus.State, bus.InstrDone);
      end
   endtask

   task automatic test_add();
      bus.IROut = 16'h3100;
      step();
      step();
      checks++;
      if ({bus.State, bus.RF_OutASel, bus.RF_OutBSel, bus.ALU_FunSel,
           bus.ALU_WF, bus.MuxASel, bus.RF_RegSel, bus.RF_FunSel,
           bus.InstrDone}
          !== {3'd2, 3'd0, 3'd1, 5'b10100, 1'b1, 2'b00, 4'b1000,
               3'b010, 1'b1}) begin
         errors++;
         $display("FAIL add_exec1 got st=%0d a=%0d b=%0d f=%b wf=%b rs=%b",
                  bus.State, bus.RF_OutASel, bus.RF_OutBSel,
                  bus.ALU_FunSel, bus.ALU_WF, bus.RF_RegSel);
      end
      step();
   endtask

   task automatic test_branch();
      bus.IROut    = 16'h1040;
      bus.FlagsOut = 4'b1000;
      step();
      step();
      checks++;
      if ({bus.State, bus.ARF_RegSel, bus.ARF_FunSel, bus.MuxBSel,
           bus.Mem_CS, bus.InstrDone}
          !== {3'd2, 3'b000, 3'b000, 2'b00, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL bne_taken_z got st=%0d rs=%b fs=%b mb=%b cs=%b d=%b",
                  bus.State, bus.ARF_RegSel, bus.ARF_FunSel,
                  bus.MuxBSel, bus.Mem_CS, bus.InstrDone);
      end
      step();
      bus.FlagsOut = 4'b0000;
      step();
      step();
      checks++;
      if ({bus.State, bus.ARF_RegSel, bus.ARF_FunSel, bus.MuxBSel,
           bus.InstrDone} !== {3'd2, 3'b100, 3'b010, 2'b11, 1'b1}) begin
         errors++;
         $display("FAIL bne_nz got st=%0d rs=%b fs=%b mb=%b d=%b",
                  bus.State, bus.ARF_RegSel, bus.ARF_FunSel,
                  bus.MuxBSel, bus.InstrDone);
      end
      step();
      bus.IROut    = 16'h0012;
      bus.FlagsOut = 4'b1000;
      step();
      step();
      checks++;
      if ({bus.ARF_RegSel, bus.ARF_FunSel, bus.MuxBSel, bus.InstrDone}
          !== {3'b100, 3'b010, 2'b11, 1'b1}) begin
         errors++;
         $display("FAIL bra got rs=%b fs=%b mb=%b d=%b",
                  bus.ARF_RegSel, bus.ARF_FunSel, bus.MuxBSel,
                  bus.InstrDone);
      end
      step();
      bus.FlagsOut = 4'b0000;
   endtask

   task automatic test_store();
      bus.IROut = 16'h5410;
      step();
      step();
      checks++;
      if ({bus.State, bus.ARF_RegSel, bus.ARF_FunSel, bus.MuxBSel,
           bus.InstrDone} !== {3'd2, 3'b010, 3'b010, 2'b11, 1'b0}) begin
         errors++;
         $display("FAIL st_exec1 got st=%0d rs=%b fs=%b mb=%b d=%b",
                  bus.State, bus.ARF_RegSel, bus.ARF_FunSel,
                  bus.MuxBSel, bus.InstrDone);
      end
      step();
      checks++;
      if ({bus.State, bus.Mem_WR, bus.Mem_CS, bus.ARF_OutDSel,
           bus.RF_OutASel, bus.ALU_FunSel, bus.MuxCSel, bus.RF_RegSel,
           bus.InstrDone}
          !== {3'd3, 1'b1, 1'b0, 2'b01, 3'd1, 5'b10000, 1'b0, 4'b0000,
               1'b1}) begin
         errors++;
         $display("FAIL st_exec2 got st=%0d wr=%b cs=%b od=%b a=%0d f=%b d=%b",
                  bus.State, bus.Mem_WR, bus.Mem_CS, bus.ARF_OutDSel,
                  bus.RF_OutASel, bus.ALU_FunSel, bus.InstrDone);
      end
      step();
      checks++;
      if (bus.State !== 3'd0) begin
         errors++;
         $display("FAIL st_next got st=%0d want=0", bus.State);
      end
   endtask

   task automatic test_load_reset();
      bus.IROut = 16'h4800;
      step();
      step();
      step();
      checks++;
      if ({bus.State, bus.MuxASel, bus.RF_RegSel, bus.Mem_CS,
           bus.Mem_WR, bus.ARF_OutDSel}
          !== {3'd3, 2'b10, 4'b0010, 1'b0, 1'b0, 2'b01}) begin
         errors++;
         $display("FAIL ld_exec2 got st=%0d ma=%b rs=%b cs=%b wr=%b od=%b",
                  bus.State, bus.MuxASel, bus.RF_RegSel, bus.Mem_CS,
                  bus.Mem_WR, bus.ARF_OutDSel);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.Mem_CS, bus.RF_RegSel, bus.InstrDone} !== 6'b1_0000_0) begin
         errors++;
         $display("FAIL ld_rst_gate got cs=%b rs=%b d=%b want 1 0000 0",
                  bus.Mem_CS, bus.RF_RegSel, bus.InstrDone);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({bus.State, bus.Mem_CS, bus.RF_RegSel, bus.IR_Write}
             !== {3'd0, 1'b1, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL ld_rst_hold%0d got st=%0d cs=%b rs=%b irw=%b",
                     i, bus.State, bus.Mem_CS, bus.RF_RegSel,
                     bus.IR_Write);
         end
      end
      rst = 1'b1;
   endtask

   task automatic test_nop();
      bus.IROut = 16'h7000;
      step();
      step();
      checks++;
      if ({bus.State, bus.InstrDone, bus.Mem_CS, bus.RF_RegSel,
           bus.ARF_RegSel, bus.ALU_WF}
          !== {3'd2, 1'b1, 1'b1, 4'b0000, 3'b000, 1'b0}) begin
         errors++;
         $display("FAIL nop_exec1 got st=%0d d=%b cs=%b rs=%b ars=%b",
                  bus.State, bus.InstrDone, bus.Mem_CS, bus.RF_RegSel,
                  bus.ARF_RegSel);
      end
      step();
      checks++;
      if (bus.State !== 3'd0) begin
         errors++;
         $display("FAIL nop_next got st=%0d want=0", bus.State);
      end
   endtask

   task automatic test_halt();
      bus.IROut = 16'hF000;
      step();
      step();
      checks++;
      if ({bus.State, bus.InstrDone} !== {3'd2, 1'b1}) begin
         errors++;
         $display("FAIL hlt_exec1 got st=%0d d=%b", bus.State, bus.InstrDone);
      end
      step();
`ifdef ALU_CTRL_HALT_EN
      for (int i = 0; i < 20; i++) begin
         checks++;
         if ({bus.State, bus.Mem_CS, bus.IR_Write, bus.InstrDone}
             !== {3'd4, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL hlt_hold%0d got st=%0d cs=%b irw=%b d=%b",
                     i, bus.State, bus.Mem_CS, bus.IR_Write, bus.InstrDone);
         end
         step();
      end
      rst = 1'b0;
      step();
      rst = 1'b1;
      checks++;
      if (bus.State !== 3'd0) begin
         errors++;
         $display("FAIL hlt_reset got st=%0d want=0", bus.State);
      end
`else
      checks++;
      if ({bus.State, bus.IR_Write} !== {3'd0, 1'b1}) begin
         errors++;
         $display("FAIL hlt_nop got st=%0d irw=%b want st=0 irw=1",
                  bus.State, bus.IR_Write);
      end
`endif
   endtask

   initial begin
      bus.IROut    = 16'h0000;
      bus.FlagsOut = 4'b0000;
      test_reset();
      test_ldi();
      test_add();
      test_branch();
      test_store();
      test_load_reset();
      test_nop();
      test_halt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/arithmetic_logic_unit_controller.md
ARITHMETIC_LOGIC_UNIT_CONTROLLER -- requirements
Module: arithmetic_logic_unit_controller

Interface
REQ-001 The block SHALL have port Clock, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port Reset, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL have port IROut, input, 16 bits: instruction register contents; [15:12] opcode, [11:10] Rx, [9:8] Ry, [7:0] imm.
REQ-004 The block SHALL have port FlagsOut, input, 4 bits: ALU flags {Z,C,N,O}, with Z at bit 3.
REQ-005 The block SHALL have these datapath control outputs, widths as listed: MuxASel 2, MuxBSel 2, MuxCSel 1, RF_OutASel 3, RF_OutBSel 3, RF_FunSel 3, RF_RegSel 4, RF_ScrSel 4, ALU_FunSel 5, ALU_WF 1, ARF_OutCSel 2, ARF_OutDSel 2, ARF_FunSel 3, ARF_RegSel 3, IR_LH 1, IR_Write 1, Mem_WR 1, Mem_CS 1.
REQ-006 The block SHALL have port State, output, 3 bits: current sequencer state.
REQ-007 The block SHALL have port InstrDone, output, 1 bit: one-cycle pulse in the last cycle of each instruction.

Function
REQ-008 The block SHALL be a Moore FSM; all outputs are combinational from State and the registered IROut/FlagsOut inputs.
REQ-009 The FSM SHALL have states FETCH_L=0, FETCH_H=1, EXEC1=2, EXEC2=3, HALT=4.
REQ-010 The idle output value SHALL be: all RegSel/ScrSel=0, IR_Write=0, Mem_CS=1 (deselected), Mem_WR=0, ALU_WF=0, InstrDone=0, other selects=0.
REQ-011 Encodings SHALL be: FunSel load=3'b010, increment=3'b001; ARF_RegSel PC=3'b100, AR=3'b010; ARF_OutDSel PC=2'b00, AR=2'b01; RF_RegSel Rx one-hot, R1=4'b1000..R4=4'b0001; RF_OutASel/OutBSel=register index; ALU_FunSel add=5'b10100, pass-A=5'b10000.
REQ-012 In FETCH_L the block SHALL drive ARF_OutDSel=PC, Mem_CS=0, Mem_WR=0, IR_Write=1, IR_LH=0, ARF_RegSel=PC, ARF_FunSel=increment, then go to FETCH_H.
REQ-013 In FETCH_H the block SHALL drive the same outputs as FETCH_L with IR_LH=1, then go to EXEC1.
REQ-014 For opcode 0x0 BRA, EXEC1 SHALL drive MuxBSel=2'b11, ARF_RegSel=PC, ARF_FunSel=load, so that PC<-imm; the instruction is done.
REQ-015 For opcode 0x1 BNE, EXEC1 SHALL perform the BRA actions only when FlagsOut[3]=0, otherwise keep idle; the instruction is done.
REQ-016 For opcode 0x2 LDI, EXEC1 SHALL drive MuxASel=2'b11, RF_RegSel=Rx, RF_FunSel=load, so that Rx<-imm; the instruction is done.
REQ-017 For opcode 0x3 ADD, EXEC1 SHALL drive RF_OutASel=Rx, RF_OutBSel=Ry, ALU_FunSel=add, ALU_WF=1, MuxASel=2'b00, RF_RegSel=Rx, RF_FunSel=load; the instruction is done.
REQ-018 For opcodes 0x4 LD and 0x5 ST, EXEC1 SHALL perform AR<-imm (MuxBSel=2'b11, ARF_RegSel=AR, load), then go to EXEC2.
REQ-019 In EXEC2 for LD, the block SHALL drive ARF_OutDSel=AR, Mem_CS=0, Mem_WR=0, MuxASel=2'b10, RF_RegSel=Rx, RF_FunSel=load.
REQ-020 In EXEC2 for ST, the block SHALL drive ARF_OutDSel=AR, RF_OutASel=Rx, ALU_FunSel=pass-A, MuxCSel=0, Mem_CS=0, Mem_WR=1.
REQ-021 For an undefined opcode the block SHALL treat it as a NOP: EXEC1 is idle and the instruction is done.
REQ-022 The block SHALL assert InstrDone in the final exec state of every instruction and return to FETCH_L on the next edge.
REQ-023 Each instruction SHALL take exactly 3 cycles (BRA/BNE/LDI/ADD/NOP) or 4 cycles (LD/ST); there is no stall input.

Reset
REQ-024 When Reset=0 at a rising edge, State SHALL become FETCH_L regardless of the current state, including mid-instruction or HALT.
REQ-025 While Reset=0, all outputs SHALL hold the idle value of REQ-010; this suppresses the FETCH_L strobes, so no register or memory write occurs during reset.

Configuration
REQ-026 With macro ALU_CTRL_HALT_EN defined, opcode 0xF HLT SHALL enter HALT with InstrDone pulsed in EXEC1; HALT holds idle outputs until reset.
REQ-027 Without ALU_CTRL_HALT_EN, opcode 0xF SHALL be a NOP and the HALT state SHALL be unreachable; an illegal State SHALL recover to FETCH_L.

Verification
REQ-028 Release reset with IROut=0x2A55 (LDI R3,0x55): the bench SHALL see State 0->1->2, EXEC1 with MuxASel=11 and RF_RegSel=0010, InstrDone=1 only there, and the next state 0.
REQ-029 For IROut=0x3100 (ADD R1,R2), EXEC1 SHALL show RF_OutASel=0, RF_OutBSel=1, ALU_FunSel=10100, ALU_WF=1, RF_RegSel=1000.
REQ-030 For BNE (IROut=0x1040), FlagsOut=4'b1000 SHALL give idle outputs in EXEC1, and FlagsOut=4'b0000 SHALL give ARF_RegSel=100 with ARF_FunSel=010.
REQ-031 For ST (IROut=0x5410), the sequence SHALL be 4 cycles, with EXEC2 showing Mem_WR=1, Mem_CS=0, ARF_OutDSel=01.
REQ-032 Asserting Reset=0 during EXEC2 of an LD SHALL give State=0 after the next edge, Mem_CS=1 for as long as Reset=0, and no RF load.
REQ-033 With ALU_CTRL_HALT_EN defined and IROut=0xF000, the FSM SHALL stay at State=4 for 20 cycles until reset; without the macro, State SHALL return to 0.
